sdrc_req_arb: RTL and testbench

Multi-port request arbiter placed in front of `sdrc_req_gen`. It shares the single SDRAM request path between NPORT application requesters. It selects one pending port round-robin, registers that port's request fields, and presents them on the req/req_ack handshake. It returns the acknowledge to the winning port and tags the request ID with the port index, so read data can be routed back.

---
 rtl/sdrc_req_arb_pkg.sv | 13 +
 rtl/sdrc_rr_pick.sv | 37 +++
 rtl/sdrc_req_arb.sv | 152 +++++++++++++++
 tb/tb_sdrc_req_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_req_arb_pkg.sv
// Shared definitions for the SDRAM request arbiter: request-ID width,
// FSM state encodings and the default starvation limit.
package sdrc_req_arb_pkg;

  localparam int unsigned SDR_REQ_ID_W    = 4;
  localparam int unsigned SDRC_STARVE_MAX = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sdrc_rr_pick.sv
// Round-robin picker: first set request strictly after ptr_i (mod NPORT),
// found by rotating a doubled request vector and priority-encoding it.
module sdrc_rr_pick #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned PW    = 2
) (
  input  logic [NPORT-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [PW-1:0]    idx_o,
  output logic             valid_o
);

  localparam int unsigned SW = PW + 1;

  logic [SW-1:0]    start;
  logic [SW-1:0]    sum;
  logic [NPORT-1:0] rot;

  always_comb begin
    start = SW'(ptr_i) + SW'(1);
    if (start >= SW'(NPORT)) start = '0;
    rot     = NPORT'({req_i, req_i} >> start);
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    // Walk downwards so the lowest rotated position wins.
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = start + SW'(i);
        if (sum >= SW'(NPORT)) sum = sum - SW'(NPORT);
        idx_o   = PW'(sum);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdrc_req_arb.sv
// Multi-port round-robin request arbiter in front of sdrc_req_gen.
// Define SDRC_ARB_PRIO_EN for strict port-0 priority with starvation guard.
module sdrc_req_arb
  import sdrc_req_arb_pkg::*;
#(
  parameter int unsigned NPORT  = 4,
  parameter int unsigned APP_AW = 30,
  parameter int unsigned APP_RW = 9,
  parameter int unsigned PW     = 2
`ifdef SDRC_ARB_PRIO_EN
  , parameter int unsigned STARVE_MAX = SDRC_STARVE_MAX
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NPORT-1:0]             p_req,
  input  logic [NPORT*(APP_AW+1)-1:0]  p_addr,
  input  logic [NPORT*(APP_AW-1)-1:0]  p_addr_mask,
  input  logic [NPORT*APP_RW-1:0]      p_len,
  input  logic [NPORT-1:0]             p_wr_n,
  input  logic [NPORT-1:0]             p_wrap,
  output logic [NPORT-1:0]             p_ack,
  output logic                         req,
  output logic [SDR_REQ_ID_W-1:0]      req_id,
  output logic [APP_AW:0]              req_addr,
  output logic [APP_AW-2:0]            req_addr_mask,
  output logic [APP_RW-1:0]            req_len,
  output logic                         req_wr_n,
  output logic                         req_wrap,
  input  logic                         req_ack,
  output logic                         arb_idle
);

  localparam int unsigned AW = APP_AW + 1;
  localparam int unsigned MW = APP_AW - 1;

  arb_state_e       state_q;
  logic [PW-1:0]    grant_q, grant_d;
  logic [PW-1:0]    rr_ptr_q;
  logic [PW-1:0]    rr_idx;
  logic             rr_vld;
  logic [AW-1:0]    addr_d;
  logic [MW-1:0]    mask_d;
  logic [APP_RW-1:0] len_d;
  logic             wr_n_d, wrap_d;

  sdrc_rr_pick #(.NPORT(NPORT), .PW(PW)) u_pick_all (
    .req_i   (p_req),
    .ptr_i   (rr_ptr_q),
    .idx_o   (rr_idx),
    .valid_o (rr_vld)
  );

`ifdef SDRC_ARB_PRIO_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]    starve_q, starve_d;
  logic [NPORT-1:0] req_oth;
  logic [PW-1:0]    oth_idx;
  logic             oth_vld;

  assign req_oth = p_req & ~NPORT'(1);

  // Same picker with port 0 masked, used once port 0 has hogged the path.
  sdrc_rr_pick #(.NPORT(NPORT), .PW(PW)) u_pick_oth (
    .req_i   (req_oth),
    .ptr_i   (rr_ptr_q),
    .idx_o   (oth_idx),
    .valid_o (oth_vld)
  );
`endif

  // Winner selection and field mux for the next grant.
  always_comb begin
    grant_d = rr_idx;
`ifdef SDRC_ARB_PRIO_EN
    starve_d = starve_q;
    if (starve_q == SW'(STARVE_MAX) && oth_vld) begin
      grant_d  = oth_idx;
      starve_d = '0;
    end else if (p_req[0]) begin
      grant_d = '0;
      if (|p_req[NPORT-1:1]) starve_d = starve_q + SW'(1);
    end else begin
      starve_d = '0;
    end
`endif
    addr_d = '0;
    mask_d = '0;
    len_d  = '0;
    wr_n_d = 1'b0;
    wrap_d = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (PW'(i) == grant_d) begin
        addr_d = p_addr[i*AW +: AW];
        mask_d = p_addr_mask[i*MW +: MW];
        len_d  = p_len[i*APP_RW +: APP_RW];
        wr_n_d = p_wr_n[i];
        wrap_d = p_wrap[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      req           <= 1'b0;
      grant_q       <= '0;
      rr_ptr_q      <= PW'(NPORT - 1);
      req_addr      <= '0;
      req_addr_mask <= '0;
      req_len       <= '0;
      req_wr_n      <= 1'b0;
      req_wrap      <= 1'b0;
`ifdef SDRC_ARB_PRIO_EN
      starve_q      <= '0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (rr_vld) begin
            state_q       <= ARB_ISSUE;
            req           <= 1'b1;
            grant_q       <= grant_d;
            req_addr      <= addr_d;
            req_addr_mask <= mask_d;
            req_len       <= len_d;
            req_wr_n      <= wr_n_d;
            req_wrap      <= wrap_d;
`ifdef SDRC_ARB_PRIO_EN
            starve_q      <= starve_d;
`endif
          end
        end
        ARB_ISSUE: begin
          if (req_ack) begin
            state_q  <= ARB_IDLE;
            req      <= 1'b0;
            rr_ptr_q <= grant_q;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // A request cut off by reset must never be acknowledged to its port.
  assign p_ack    = (state_q == ARB_ISSUE && req_ack && reset_n) ? (NPORT'(1) << grant_q) : '0;
  assign req_id   = SDR_REQ_ID_W'(grant_q);
  assign arb_idle = (state_q == ARB_IDLE) && !(|p_req);

endmodule

// File: tb/tb_sdrc_req_arb.sv
// Randomized bench for sdrc_req_arb against a transaction-level arbiter model.
module tb_sdrc_req_arb;

  localparam int NP   = 4;
  localparam int SMAX = 4;

  logic            clk;
  logic            reset_n;
  logic [NP-1:0]   p_req;
  logic [NP*31-1:0] p_addr;
  logic [NP*29-1:0] p_addr_mask;
  logic [NP*9-1:0] p_len;
  logic [NP-1:0]   p_wr_n;
  logic [NP-1:0]   p_wrap;
  logic [NP-1:0]   p_ack;
  logic            req;
  logic [sdrc_req_arb_pkg::SDR_REQ_ID_W-1:0] req_id;
  logic [30:0]     req_addr;
  logic [28:0]     req_addr_mask;
  logic [8:0]      req_len;
  logic            req_wr_n;
  logic            req_wrap;
  logic            req_ack;
  logic            arb_idle;

  sdrc_req_arb dut (
    .clk(clk), .reset_n(reset_n), .p_req(p_req), .p_addr(p_addr),
    .p_addr_mask(p_addr_mask), .p_len(p_len), .p_wr_n(p_wr_n), .p_wrap(p_wrap),
    .p_ack(p_ack), .req(req), .req_id(req_id), .req_addr(req_addr),
    .req_addr_mask(req_addr_mask), .req_len(req_len), .req_wr_n(req_wr_n),
    .req_wrap(req_wrap), .req_ack(req_ack), .arb_idle(arb_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Requester side
  logic [NP-1:0] act;
  logic [NP-1:0] en;
  logic [30:0]   fa[NP];
  logic [28:0]   fm[NP];
  logic [8:0]    fl[NP];
  logic          fw[NP];
  logic          fx[NP];
  int unsigned   req_pct, ack_pct, drop_pct;

  // Model of the arbiter
  bit            m_busy;
  int            m_grant, m_ptr, m_cnt;
  logic [30:0]   m_addr;
  logic [28:0]   m_mask;
  logic [8:0]    m_len;
  logic          m_wr, m_wrap;

  // Grant log
  int            gq[$];
  int            aq[$];
  logic [30:0]   adq[$];
  logic [3:0]    pq[$];
  logic [3:0]    idq[$];

  int exp_b[5]  = '{0, 1, 2, 3, 0};
  int exp_p[10] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_find(input logic [NP-1:0] r, input int ptr, input bit skip0);
    rr_find = -1;
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (ptr + k) % NP;
      if (rr_find < 0 && r[p] && !(skip0 && p == 0)) rr_find = p;
    end
  endfunction

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_ptr = NP - 1; m_cnt = 0;
    m_addr = '0; m_mask = '0; m_len = '0; m_wr = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_step(input logic rst, input logic [NP-1:0] r, input logic ack);
    if (!rst) begin
      model_reset();
    end else if (!m_busy) begin
      int w;
      w = -1;
`ifdef SDRC_ARB_PRIO_EN
      if (m_cnt == SMAX && rr_find(r, m_ptr, 1'b1) >= 0) begin
        w = rr_find(r, m_ptr, 1'b1);
        m_cnt = 0;
      end else if (r[0]) begin
        w = 0;
        if (r[NP-1:1] != '0) m_cnt++;
      end else begin
        w = rr_find(r, m_ptr, 1'b0);
        if (w >= 0) m_cnt = 0;
      end
`else
      w = rr_find(r, m_ptr, 1'b0);
`endif
      if (w >= 0) begin
        m_busy = 1; m_grant = w;
        m_addr = fa[w]; m_mask = fm[w]; m_len = fl[w]; m_wr = fw[w]; m_wrap = fx[w];
      end
    end else if (ack) begin
      m_busy = 0;
      m_ptr  = m_grant;
    end
  endtask

  task automatic clear_log();
    gq.delete(); aq.delete(); adq.delete(); pq.delete(); idq.delete();
  endtask

  // One clock cycle: drive after the edge, check at the falling edge, advance model.
  task automatic cycle(input logic rst);
    logic [3:0] e_ack;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++) begin
      if (act[i] && $urandom_range(99) < drop_pct) act[i] = 1'b0;
      else if (!act[i] && en[i] && $urandom_range(99) < req_pct) begin
        act[i] = 1'b1;
        fa[i] = 31'($urandom); fm[i] = 29'($urandom); fl[i] = 9'($urandom);
        fw[i] = 1'($urandom);  fx[i] = 1'($urandom);
      end
      if (!act[i]) begin
        fa[i] = 31'($urandom); fm[i] = 29'($urandom); fl[i] = 9'($urandom);
      end
      p_addr[i*31 +: 31]      = fa[i];
      p_addr_mask[i*29 +: 29] = fm[i];
      p_len[i*9 +: 9]         = fl[i];
      p_wr_n[i]               = fw[i];
      p_wrap[i]               = fx[i];
    end
    p_req   = act;
    reset_n = rst;
    req_ack = ($urandom_range(99) < ack_pct);
    @(negedge clk);
    e_ack = (m_busy && req_ack && rst) ? 4'(1 << m_grant) : 4'b0;
    chk("req",       64'(req),           64'(m_busy));
    chk("req_id",    64'(req_id),        64'(m_grant));
    chk("req_addr",  64'(req_addr),      64'(m_addr));
    chk("req_mask",  64'(req_addr_mask), 64'(m_mask));
    chk("req_len",   64'(req_len),       64'(m_len));
    chk("req_wr_n",  64'(req_wr_n),      64'(m_wr));
    chk("req_wrap",  64'(req_wrap),      64'(m_wrap));
    chk("p_ack",     64'(p_ack),         64'(e_ack));
    chk("arb_idle",  64'(arb_idle),      64'(!m_busy && p_req == '0));
    for (int i = 0; i < NP; i++) begin
      if (p_ack[i]) begin
        gq.push_back(i); aq.push_back(cyc); adq.push_back(req_addr);
        pq.push_back(p_ack); idq.push_back(req_id);
      end
    end
    model_step(rst, p_req, req_ack);
    for (int i = 0; i < NP; i++) if (p_ack[i]) act[i] = 1'b0;
  endtask

  task automatic reset_all();
    cycle(1'b0);
    cycle(1'b0);
  endtask

  initial begin
    int rise;
    reset_n = 1'b0; req_ack = 1'b0; p_req = '0; p_addr = '0; p_addr_mask = '0;
    p_len = '0; p_wr_n = '0; p_wrap = '0;
    act = '0; en = '0; req_pct = 0; ack_pct = 0; drop_pct = 0;
    for (int i = 0; i < NP; i++) begin
      fa[i] = '0; fm[i] = '0; fl[i] = '0; fw[i] = 1'b0; fx[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state
    cycle(1'b0);
    chk("rst_req",  64'(req),      64'(0));
    chk("rst_pack", 64'(p_ack),    64'(0));
    chk("rst_idle", 64'(arb_idle), 64'(1));
    chk("rst_addr", 64'(req_addr), 64'(0));

    // Single port-2 request, req_ack held high
    act[2] = 1'b1; fa[2] = 31'h100; fl[2] = 9'd8; fm[2] = '0; fw[2] = 1'b1; fx[2] = 1'b0;
    ack_pct = 100;
    clear_log();
    rise = cyc + 1;
    repeat (4) cycle(1'b1);
    chk("a_cnt", 64'(gq.size()), 64'(1));
    if (gq.size() >= 1) begin
      chk("a_port",  64'(gq[0]),       64'(2));
      chk("a_lat",   64'(aq[0] - rise), 64'(1));
      chk("a_addr",  64'(adq[0]),      64'(32'h100));
      chk("a_pack",  64'(pq[0]),       64'(4'b0100));
      chk("a_id",    64'(idq[0]),      64'(2));
    end

`ifdef SDRC_ARB_PRIO_EN
    // Port 0 and port 3 both requesting continuously
    act = '0; en = 4'b1001; req_pct = 0;
    reset_all();
    req_pct = 100; ack_pct = 100;
    clear_log();
    repeat (24) cycle(1'b1);
    chk("p_cnt", 64'(gq.size() >= 10), 64'(1));
    if (gq.size() >= 10)
      for (int i = 0; i < 10; i++) chk("p_order", 64'(gq[i]), 64'(exp_p[i]));
`else
    // All four ports requesting continuously, req_ack always high
    act = '0; en = 4'b1111; req_pct = 0;
    reset_all();
    req_pct = 100; ack_pct = 100;
    clear_log();
    rise = cyc + 1;
    repeat (12) cycle(1'b1);
    chk("b_cnt", 64'(gq.size() >= 5), 64'(1));
    if (gq.size() >= 5) begin
      chk("b_first", 64'(aq[0] - rise), 64'(1));
      for (int i = 0; i < 5; i++) chk("b_order", 64'(gq[i]), 64'(exp_b[i]));
      for (int i = 1; i < 5; i++) chk("b_gap", 64'(aq[i] - aq[i-1]), 64'(2));
    end
`endif

    // Random traffic: slow acknowledges, some protocol drops
    en = 4'b1111; req_pct = 30; ack_pct = 35; drop_pct = 5;
    repeat (400) cycle(1'b1);
    req_pct = 85; ack_pct = 90; drop_pct = 0;
    repeat (300) cycle(1'b1);

    // Reset while a request is outstanding
    req_pct = 100; ack_pct = 0;
    repeat (2) cycle(1'b1);
    chk("d_busy", 64'(req), 64'(1));
    ack_pct = 100;
    cycle(1'b0);
    chk("d_pack_rst", 64'(p_ack), 64'(0));
    cycle(1'b1);
    chk("d_req", 64'(req), 64'(0));
    clear_log();
    repeat (3) cycle(1'b1);
    chk("d_cnt", 64'(gq.size() >= 1), 64'(1));
    if (gq.size() >= 1) chk("d_first", 64'(gq[0]), 64'(0));

    // Mixed random tail with occasional resets
    req_pct = 50; ack_pct = 60; drop_pct = 3;
    for (int i = 0; i < 300; i++) cycle(($urandom_range(99) < 3) ? 1'b0 : 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
